// File: rtl/popcount_pipe.sv
// Pipelined population count with a valid/ready handshake and a birth/survive life rule.
// Registered binary adder tree, one stage per level; the whole pipe advances or holds as a unit.
module popcount_pipe #(
  parameter int         N       = 8,
  parameter logic [N:0] BIRTH   = (N+1)'(8),
  parameter logic [N:0] SURVIVE = (N+1)'(12)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_bits,
  input  logic                     in_alive,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N+1)-1:0]   out_count,
  output logic                     out_next
);

  localparam int W      = $clog2(N + 1);
  localparam int L      = $clog2(N);
  localparam int LEAVES = 1 << L;

  function automatic logic life_rule(input logic alive, input logic [W-1:0] cnt);
    return alive ? SURVIVE[cnt] : BIRTH[cnt];
  endfunction

  logic [LEAVES-1:0] w_leaf;
  logic              w_adv;
  logic [L:1]        r_vld;
  logic [L:1]        r_alive;
  logic [L:0]        w_top;

  generate
    if (LEAVES > N) begin : g_pad
      assign w_leaf = {{(LEAVES - N){1'b0}}, in_bits};
    end else begin : g_nopad
      assign w_leaf = in_bits;
    end
  endgenerate

  // A stalled final stage freezes every stage, so bubbles are kept rather than squeezed out.
  assign w_adv    = !r_vld[L] || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_alive <= '0;
    end else if (w_adv) begin
      r_vld[1]   <= in_valid;
      r_alive[1] <= in_alive;
      for (int j = 2; j <= L; j++) begin
        r_vld[j]   <= r_vld[j-1];
        r_alive[j] <= r_alive[j-1];
      end
    end
  end

  // Level j holds LEAVES>>j sums, each j+1 bits wide; the widths grow just enough to never overflow.
  generate
    for (genvar j = 1; j <= L; j++) begin : g_lvl
      for (genvar k = 0; k < (LEAVES >> j); k++) begin : g_node
        logic [j:0] w_add;
        logic [j:0] r_sum;

        if (j == 1) begin : g_first
          assign w_add = {1'b0, w_leaf[2*k]} + {1'b0, w_leaf[2*k+1]};
        end else begin : g_inner
          assign w_add = {1'b0, g_lvl[j-1].g_node[2*k].r_sum}
                       + {1'b0, g_lvl[j-1].g_node[2*k+1].r_sum};
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_sum <= '0;
          end else if (w_adv) begin
            r_sum <= w_add;
          end
        end
      end
    end
  endgenerate

  assign w_top     = g_lvl[L].g_node[0].r_sum;
  assign out_count = w_top[W-1:0];
  assign out_valid = r_vld[L];
  assign out_next  = life_rule(r_alive[L], out_count);

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe: N=8 instance with an in-order scoreboard, plus an N=5 instance.
module tb_popcount_pipe;

  typedef struct {
    logic [7:0] bits;
    logic       alive;
    logic [3:0] cnt;
    logic       nxt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       i8_valid, w8_in_ready, i8_alive, o8_valid, o8_ready, o8_next;
  logic [7:0] i8_bits;
  logic [3:0] o8_count;
  logic       i5_valid, w5_in_ready, i5_alive, o5_valid, o5_ready, o5_next;
  logic [4:0] i5_bits;
  logic [2:0] o5_count;

  int   n_vec;
  int   n_err;
  vec_t tbl [13];
  vec_t q [$];
  vec_t cur8;
  vec_t mon_e;

  popcount_pipe #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(i8_valid), .in_ready(w8_in_ready), .in_bits(i8_bits), .in_alive(i8_alive),
    .out_valid(o8_valid), .out_ready(o8_ready), .out_count(o8_count), .out_next(o8_next)
  );

  popcount_pipe #(.N(5)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(i5_valid), .in_ready(w5_in_ready), .in_bits(i5_bits), .in_alive(i5_alive),
    .out_valid(o5_valid), .out_ready(o5_ready), .out_count(o5_count), .out_next(o5_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input vec_t v);
    i8_valid = 1'b1;
    i8_bits  = v.bits;
    i8_alive = v.alive;
    cur8     = v;
  endtask

  task automatic idle8();
    i8_valid = 1'b0;
    i8_bits  = 8'h00;
    i8_alive = 1'b0;
  endtask

  // Scoreboard: record beats that will be taken at the coming edge, retire beats the sink takes.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (o8_valid && o8_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got count %0d, expected no beat", o8_count);
        end else begin
          mon_e = q.pop_front();
          chk("stream_count", o8_count, mon_e.cnt);
          chk("stream_next", o8_next, mon_e.nxt);
        end
      end
      if (i8_valid && w8_in_ready) q.push_back(cur8);
    end
  end

  initial begin
    int   idx;
    int   stall_left;
    bit   stall_done;
    logic [3:0] snap_cnt;
    logic snap_nxt;
    logic acc;

    n_vec = 0;
    n_err = 0;
    // Default rule: birth on 3, survive on 2 or 3.
    tbl[0]  = '{8'h00, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{8'hFF, 1'b0, 4'd8, 1'b0};
    tbl[2]  = '{8'hA5, 1'b0, 4'd4, 1'b0};
    tbl[3]  = '{8'h07, 1'b0, 4'd3, 1'b1};
    tbl[4]  = '{8'h03, 1'b1, 4'd2, 1'b1};
    tbl[5]  = '{8'h0F, 1'b1, 4'd4, 1'b0};
    tbl[6]  = '{8'h01, 1'b1, 4'd1, 1'b0};
    tbl[7]  = '{8'h07, 1'b1, 4'd3, 1'b1};
    tbl[8]  = '{8'h80, 1'b0, 4'd1, 1'b0};
    tbl[9]  = '{8'h3C, 1'b1, 4'd4, 1'b0};
    tbl[10] = '{8'h55, 1'b1, 4'd4, 1'b0};
    tbl[11] = '{8'h0E, 1'b0, 4'd3, 1'b1};
    tbl[12] = '{8'hC0, 1'b1, 4'd2, 1'b1};
    cur8 = tbl[0];

    // Reset with random inputs.
    rst      = 1'b1;
    i8_valid = 1'($urandom_range(0, 1));
    i8_bits  = 8'($urandom);
    i8_alive = 1'($urandom_range(0, 1));
    o8_ready = 1'($urandom_range(0, 1));
    i5_valid = 1'b1;
    i5_bits  = 5'($urandom);
    i5_alive = 1'b1;
    o5_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", o8_valid, 0);
    chk("rst_out_count", o8_count, 0);
    chk("rst_in_ready", w8_in_ready, 1);
    chk("rst_out_next", o8_next, 0);
    chk("rst_out_valid5", o5_valid, 0);
    chk("rst_out_count5", o5_count, 0);

    idle8();
    o8_ready = 1'b1;
    i5_valid = 1'b0;
    i5_bits  = 5'b0;
    i5_alive = 1'b0;
    rst      = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("post_rst_idle", o8_valid, 0);
    end

    // Latency: a beat presented after edge e is visible after edge e+3.
    drive8(tbl[0]); step();
    chk("lat_e1_valid", o8_valid, 0);
    drive8(tbl[1]); step();
    chk("lat_e2_valid", o8_valid, 0);
    drive8(tbl[2]); step();
    chk("lat_e3_valid", o8_valid, 1);
    chk("lat_e3_count", o8_count, 0);
    drive8(tbl[3]); step();
    chk("lat_e4_count", o8_count, 8);
    idle8(); step();
    chk("lat_e5_count", o8_count, 4);
    step();
    chk("lat_e6_count", o8_count, 3);
    step();
    chk("lat_e7_valid", o8_valid, 0);

    // Full table streamed back to back; the scoreboard compares each beat.
    for (int i = 0; i < 13; i++) begin
      drive8(tbl[i]);
      step();
    end
    idle8();
    repeat (5) step();

    // Backpressure: 6 beats, sink stalls 4 cycles once the first result shows.
    idx = 0;
    stall_left = 0;
    stall_done = 0;
    snap_cnt = '0;
    snap_nxt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 6) drive8(tbl[idx + 4]);
      else idle8();
      if (!stall_done && o8_valid) begin
        stall_left = 4;
        stall_done = 1;
        snap_cnt   = o8_count;
        snap_nxt   = o8_next;
      end
      o8_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", w8_in_ready, 0);
        chk("stall_valid", o8_valid, 1);
        chk("stall_count", o8_count, snap_cnt);
        chk("stall_next", o8_next, snap_nxt);
        stall_left--;
      end
      acc = i8_valid && w8_in_ready;
      step();
      if (acc) idx++;
    end
    o8_ready = 1'b1;
    chk("bp_all_sent", idx, 6);

    // Reset with three beats in flight.
    drive8(tbl[1]); step();
    drive8(tbl[2]); step();
    drive8(tbl[3]); step();
    idle8();
    rst = 1'b1;
    #1;
    chk("midrst_valid", o8_valid, 0);
    chk("midrst_count", o8_count, 0);
    chk("midrst_in_ready", w8_in_ready, 1);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_no_ghost", o8_valid, 0);
    end
    drive8(tbl[11]); step();
    drive8(tbl[12]); step();
    idle8();
    repeat (6) step();

    // Non-power-of-two width.
    i5_valid = 1'b1; i5_bits = 5'b11111; step();
    chk("n5_e1_valid", o5_valid, 0);
    i5_bits = 5'b10001; step();
    chk("n5_e2_valid", o5_valid, 0);
    i5_bits = 5'b00000; step();
    chk("n5_e3_valid", o5_valid, 1);
    chk("n5_e3_count", o5_count, 5);
    i5_valid = 1'b0; step();
    chk("n5_e4_count", o5_count, 2);
    step();
    chk("n5_e5_valid", o5_valid, 1);
    chk("n5_e5_count", o5_count, 0);
    step();
    chk("n5_e6_valid", o5_valid, 0);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
